hour_bcd_counter: RTL and testbench
===================================

// Module: hour_bcd_counter
// PURPOSE
//   Two-digit BCD hour counter, 00..23, for the digital clock datapath.
//   Advances on the one-cycle carry pulse from the minute stage.
//   Supports time-set by key increment and by parallel load.
//   Drives the 24->12 hour display converter directly downstream.
//   Emits a one-cycle day-carry pulse on the natural 23->00 wrap.
// PARAMETERS
//   HOUR_MAX_H  2  tens digit of last valid hour (23)
//   HOUR_MAX_L  3  units digit of last valid hour (23)
// PORTS
//   CP      in   1  system clock, all logic on rising edge
//   CR      in   1  reset, synchronous, active-high
//   EN      in   1  minute carry, one-cycle pulse: +1 hour
//   SET     in   1  level: time-set mode (EN ignored, ADJ active)
//   ADJ     in   1  debounced key level; rising edge = +1 hour in set mode
//   LD      in   1  one-cycle load strobe
//   LDH     in   4  BCD tens digit to load
//   LDL     in   4  BCD units digit to load
//   HourH   out  4  BCD tens digit (0..2)
//   HourL   out  4  BCD units digit (0..9)
//   CO      out  1  day carry, one-cycle pulse on EN-driven 23->00
//   ERR     out  1  one-cycle pulse: LD rejected (invalid value)
// BEHAVIOUR
//   Reset (CR=1 at CP edge): HourH=0, HourL=0, CO=0, ERR=0, adj_q=0.
//   Output timing: all outputs are registered; a change appears one CP after
//     the causing input is sampled.
//   ADJ edge detect: adj_q <= ADJ each cycle; adj_rise = ADJ & ~adj_q.
//     adj_q updates in every non-reset cycle, including cycles where SET=0.
//   Priority per cycle, highest first:
//     CR > LD > (SET & adj_rise) > (~SET & EN).
//   Increment rule:
//     HourL==9                  -> HourL=0, HourH+1
//     HourH:HourL == 2:3        -> 0:0
//     otherwise                 -> HourL+1
//   LD: accepted if LDH<=2, LDL<=9, and (LDH<2 or LDL<=3).
//     Accepted -> HourH=LDH, HourL=LDL; ERR=0.
//     Rejected -> hour held; ERR=1 for one cycle.
//   CO=1 only in the cycle after an EN-driven wrap 23->00; otherwise 0.
//     ADJ wrap and LD to 00 never assert CO.
//   Discard rules:
//     EN while SET=1: discarded, not queued.
//     EN in the same cycle as LD: discarded.
//     adj_rise while SET=0: ignored.
//     ADJ held high: exactly one increment per rising edge.
//     SET rising while ADJ already high: no increment (adj_q already 1).
//   Reset mid-set (CR during SET/ADJ/LD): reset wins; state returns to 00.
//   Invariant: outputs always valid BCD within 00..23; illegal state
//     unreachable.
// STRUCTURE
//   Shared include clock_defs.vh:
//     BCD_MAX=9, HOUR_MAX_H, HOUR_MAX_L, digit-width constant.
//     Shared with the minute/second counters and the 24->12 converter.
//   Sub-module bcd_digit_cnt:
//     4-bit BCD digit; inputs inc, clr, load, ld_val; outputs q, at_max.
//     Instantiated twice; tens digit wrap condition supplied from the top.
//   Top-level logic: ADJ edge detect, priority mux, LD validation, CO/ERR regs.
// TESTING
//   1 Reset: CR=1 two cycles, then EN pulses
//       -> 00 after reset; 01, 02 ... on successive EN.
//   2 Decimal carry: LD 0:9, then EN
//       -> 1:0, CO=0.
//   3 Day wrap: LD 2:3, then EN
//       -> 0:0, CO=1 for exactly one cycle.
//   4 Set mode: SET=1, LD 2:3, ADJ held high 5 cycles, plus EN pulses
//       -> single increment to 0:0; CO=0; EN has no effect.
//   5 Invalid load: LD with 2:5, then 3:0, then 1:A
//       -> hour unchanged, ERR pulses each time.
//     Valid load: LD 1:9 -> 1:9, ERR=0.
//   6 Collisions: LD 0:5 with EN same cycle -> 0:5.
//     Reset during SET with ADJ rising -> 0:0, CO=0, ERR=0.

Source files
------------

// File: rtl/hour_bcd_counter_pkg.sv
// Shared clock-datapath constants, the hour-load validity check and the
// per-cycle action encoding used by the hour counter.
package hour_bcd_counter_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_MAX        = 4'd9;
    localparam digit_t DEF_HOUR_MAX_H = 4'd2;
    localparam digit_t DEF_HOUR_MAX_L = 4'd3;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_LOAD   = 2'd1,
        ACT_REJECT = 2'd2,
        ACT_INC    = 2'd3
    } hour_act_e;

    // A loaded hour must be two BCD digits no later than max_h:max_l.
    function automatic logic hour_load_ok(input digit_t h, input digit_t l,
                                          input digit_t max_h, input digit_t max_l);
        return (h <= max_h) && (l <= BCD_MAX) && ((h < max_h) || (l <= max_l));
    endfunction

endpackage

// File: rtl/hour_bcd_counter_bcd_digit_cnt.sv
// One BCD digit register with clear, parallel load and increment; wraps to 0
// after reaching max_val, and flags at_max so the caller can build carries.
module hour_bcd_counter_bcd_digit_cnt
    import hour_bcd_counter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    input  logic   clr,
    input  logic   load,
    input  digit_t ld_val,
    input  digit_t max_val,
    output digit_t q,
    output logic   at_max
);

    digit_t q_r;

    // Digit state: reset, then clear > load > increment > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 4'd0;
        end else if (clr) begin
            q_r <= 4'd0;
        end else if (load) begin
            q_r <= ld_val;
        end else if (inc) begin
            q_r <= at_max ? 4'd0 : q_r + 4'd1;
        end else begin
            q_r <= q_r;
        end
    end

    assign q      = q_r;
    assign at_max = (q_r == max_val);

endmodule

// File: rtl/hour_bcd_counter.sv
// Two-digit BCD hour counter 00..23: minute-carry advance, key-set
// increment, validated parallel load, day-carry and load-error pulses.
module hour_bcd_counter
    import hour_bcd_counter_pkg::*;
#(
    parameter digit_t HOUR_MAX_H = DEF_HOUR_MAX_H,
    parameter digit_t HOUR_MAX_L = DEF_HOUR_MAX_L
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       EN,
    input  logic       SET,
    input  logic       ADJ,
    input  logic       LD,
    input  logic [3:0] LDH,
    input  logic [3:0] LDL,
    output logic [3:0] HourH,
    output logic [3:0] HourL,
    output logic       CO,
    output logic       ERR
);

    logic      adj_q_r;
    logic      co_r;
    logic      err_r;
    logic      adj_rise_s;
    logic      load_ok_s;
    logic      at_last_s;
    logic      units_at_max_s;
    logic      tens_at_max_s;
    hour_act_e act_s;
    logic      load_s;
    logic      inc_s;
    logic      wrap_s;
    logic      co_d_s;
    logic      err_d_s;

    assign adj_rise_s = ADJ & ~adj_q_r;
    assign load_ok_s  = hour_load_ok(LDH, LDL, HOUR_MAX_H, HOUR_MAX_L);
    assign at_last_s  = tens_at_max_s && (HourL == HOUR_MAX_L);

    // Priority select: LD over key-set increment over minute carry.
    always_comb begin
        act_s = ACT_HOLD;
        if (LD) begin
            act_s = load_ok_s ? ACT_LOAD : ACT_REJECT;
        end else if (SET) begin
            act_s = adj_rise_s ? ACT_INC : ACT_HOLD;
        end else if (EN) begin
            act_s = ACT_INC;
        end else begin
            act_s = ACT_HOLD;
        end
    end

    // Decode the selected action into digit controls and next pulse values.
    always_comb begin
        load_s  = 1'b0;
        inc_s   = 1'b0;
        err_d_s = 1'b0;
        case (act_s)
            ACT_LOAD:   load_s  = 1'b1;
            ACT_REJECT: err_d_s = 1'b1;
            ACT_INC:    inc_s   = 1'b1;
            ACT_HOLD:   load_s  = 1'b0;
            default:    load_s  = 1'b0;
        endcase
        wrap_s = inc_s & at_last_s;
        // Only a minute-carry wrap is a day carry; key-set wraps stay silent.
        co_d_s = wrap_s & ~SET;
    end

    hour_bcd_counter_bcd_digit_cnt u_units (
        .clk    (CP),
        .rst    (CR),
        .inc    (inc_s),
        .clr    (wrap_s),
        .load   (load_s),
        .ld_val (LDL),
        .max_val(BCD_MAX),
        .q      (HourL),
        .at_max (units_at_max_s)
    );

    hour_bcd_counter_bcd_digit_cnt u_tens (
        .clk    (CP),
        .rst    (CR),
        .inc    (inc_s & units_at_max_s),
        .clr    (wrap_s),
        .load   (load_s),
        .ld_val (LDH),
        .max_val(HOUR_MAX_H),
        .q      (HourH),
        .at_max (tens_at_max_s)
    );

    // Key edge history and registered CO/ERR pulses.
    always_ff @(posedge CP) begin
        if (CR) begin
            adj_q_r <= 1'b0;
            co_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            adj_q_r <= ADJ;
            co_r    <= co_d_s;
            err_r   <= err_d_s;
        end
    end

    assign CO  = co_r;
    assign ERR = err_r;

endmodule

// File: tb/tb_hour_bcd_counter.sv
// Table-driven bench for hour_bcd_counter with a scoreboard queue of
// expected outputs, plus hand-written multi-cycle corner sequences.
module tb_hour_bcd_counter;

    logic       CP = 1'b0;
    logic       CR = 1'b1, EN = 1'b0, SET = 1'b0, ADJ = 1'b0, LD = 1'b0;
    logic [3:0] LDH = 4'd0, LDL = 4'd0;
    logic [3:0] HourH, HourL;
    logic       CO, ERR;

    hour_bcd_counter dut (
        .CP(CP), .CR(CR), .EN(EN), .SET(SET), .ADJ(ADJ), .LD(LD),
        .LDH(LDH), .LDL(LDL), .HourH(HourH), .HourL(HourL), .CO(CO), .ERR(ERR)
    );

    always #5 CP = ~CP;

    typedef struct {
        string      tag;
        logic       cr, en, set, adj, ld;
        logic [3:0] ldh, ldl, eh, el;
        logic       eco, eerr;
    } vec_t;

    typedef struct {
        string      tag;
        logic [3:0] h, l;
        logic       co, err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input string tag, input logic cr, en, set, adj, ld,
                                input logic [3:0] ldh, ldl, eh, el, input logic eco, eerr);
        vec_t v;
        v.tag = tag; v.cr = cr; v.en = en; v.set = set; v.adj = adj; v.ld = ld;
        v.ldh = ldh; v.ldl = ldl; v.eh = eh; v.el = el; v.eco = eco; v.eerr = eerr;
        return v;
    endfunction

    task automatic cmp(input string name, input string what, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %0h, expected %0h", name, what, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge CP);
        CR = v.cr; EN = v.en; SET = v.set; ADJ = v.adj; LD = v.ld; LDH = v.ldh; LDL = v.ldl;
        e.tag = v.tag; e.h = v.eh; e.l = v.el; e.co = v.eco; e.err = v.eerr;
        sb.push_back(e);
        @(posedge CP);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: empty queue at %s", v.tag);
        end else begin
            got = sb.pop_front();
            cmp(got.tag, "HourH", HourH, got.h);
            cmp(got.tag, "HourL", HourL, got.l);
            cmp(got.tag, "CO", {3'b000, CO}, {3'b000, got.co});
            cmp(got.tag, "ERR", {3'b000, ERR}, {3'b000, got.err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 tag          cr    en    set   adj   ld    ldh   ldl   eh    el    co    err
        vecs.push_back(mk("rst0",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("rst1",     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("en01",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0));
        vecs.push_back(mk("en02",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk("idle02",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk("en03",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0));
        vecs.push_back(mk("ld09",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9, 4'd0, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("carry10",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("ld23",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 4'd2, 4'd3, 1'b0, 1'b0));
        vecs.push_back(mk("wrap00",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0));
        vecs.push_back(mk("co_off",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("ld12",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 4'd1, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk("bad25",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5, 4'd1, 4'd2, 1'b0, 1'b1));
        vecs.push_back(mk("err_off",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk("bad30",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1));
        vecs.push_back(mk("bad1A",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd10, 4'd1, 4'd2, 1'b0, 1'b1));
        vecs.push_back(mk("ld19",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd9, 4'd1, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("en20",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("ld05_en",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5, 4'd0, 4'd5, 1'b0, 1'b0));
        vecs.push_back(mk("set_en",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0));
        vecs.push_back(mk("adj_noset",1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0));
        vecs.push_back(mk("set_adjhi",1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0));
        vecs.push_back(mk("adj_lo",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0));
        vecs.push_back(mk("adj_rise", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0));
        vecs.push_back(mk("adj_hold", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0));
        vecs.push_back(mk("set_off",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Set mode: load 23, then a long ADJ press with EN pulses gives one silent wrap.
        apply(mk("s4_ld23",  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 4'd2, 4'd3, 1'b0, 1'b0));
        apply(mk("s4_press", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++) begin
            apply(mk("s4_held", 1'b0, ((k % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0,
                     4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        end
        apply(mk("s4_rel",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        apply(mk("s4_exit",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));

        // LD beats an ADJ rising edge in set mode.
        apply(mk("ld_vs_adj", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 4'd7, 4'd1, 4'd7, 1'b0, 1'b0));
        apply(mk("ld_vs_adj2",1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 4'd7, 1'b0, 1'b0));

        // Reset during set with ADJ rising and a bad load: reset wins and clears edge history.
        apply(mk("cr_mid_set",1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0));
        apply(mk("post_cr",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0));
        apply(mk("post_cr2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0));

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: %0d expected entries left unchecked", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
